feistel_decryptor: RTL and testbench
====================================

# feistel_decryptor

Iterative DES decryption engine. It accepts one 64-bit ciphertext block over a valid/ready handshake and runs the 16 Feistel rounds one per clock, applying the subkey schedule in reverse order (subkey_15 down to subkey_0). It returns the 64-bit plaintext over a second valid/ready handshake. It is the receive-side counterpart of the combinational `feistel_network` encryptor and takes the same 16-subkey schedule from the key-schedule logic.

## Interface
Parameters:
- ROUNDS, 16: Feistel round count. Fixed for DES; it also sets the round-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  cphrtxt is valid
- in_ready  output  1  engine can accept a block
- cphrtxt  input  64  ciphertext block
- subkey_0 … subkey_15  input  48 each  encryption-order subkeys; must be held stable from acceptance until out_valid && out_ready
- out_valid  output  1  plntxt is valid
- out_ready  input  1  downstream accepts plntxt
- plntxt  output  64  recovered plaintext
- busy  output  1  high in RUN or DONE

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: L ← IP(cphrtxt)[63:32], R ← IP(cphrtxt)[31:0], cnt ← 15, go to RUN.
- RUN, each cycle:
  - Apply one round with k = subkey_cnt: L ← R, R ← L ^ f(R, k).
  - If cnt==0 go to DONE; otherwise cnt ← cnt−1.
- DONE:
  - out_valid=1 and plntxt = IP⁻¹({R, L}), i.e. the final swap followed by the inverse permutation.
  - plntxt is computed combinationally from the registered L/R, so it is stable while out_valid is held.
  - On out_ready go to IDLE.
- in_valid outside IDLE is ignored. in_ready is low, so no block is accepted and none is lost.
- cnt is 4 bits, counts down only and never wraps. The transition out of RUN is taken at cnt==0.
- Reset values: state=IDLE, L=R=0, cnt=0, in_ready=1 (combinational from IDLE), out_valid=0, busy=0, plntxt=IP⁻¹(0).
- Reset asserted mid-operation: the block in flight is discarded, with no out_valid pulse. The first cycle after deassertion is in IDLE.
- Simultaneous out_valid && out_ready in DONE completes the transfer. in_ready rises on the following cycle; there is no same-cycle pass-through.

## Timing
- Acceptance at edge N. The rounds run on edges N+1 … N+16, and out_valid is high after edge N+16.
- Latency from acceptance to first out_valid: 16 cycles.
- Minimum initiation interval: 18 cycles (accept + 16 rounds + output handshake). Add extra cycles for each cycle out_ready is low.
- in_ready, out_valid and busy are decoded directly from registered state, with no combinational path from inputs.
- Critical path is one round: expansion, 48-bit XOR, S-boxes, P permutation and 32-bit XOR, plus the 16:1 subkey mux.

## Structure
- Package `des_pkg`:
  - BLOCK_W=64, HALF_W=32, SUBKEY_W=48, ROUNDS=16
  - state enum {IDLE, RUN, DONE}
  - typedef for the 16×48 subkey array
- Existing `round`, `initial_permutation` and `inv_permutation` modules are instantiated once each.
- New sub-module `subkey_select`: 16:1 48-bit mux indexed by cnt.
- Top level holds the FSM, the L/R registers and the counter.

## Test plan
- FIPS vector, with the subkeys for key 133457799BBCDFF1 (subkey_0=1B02EFFC7072, subkey_15=CB3D8B0E17F5):
  - Stimulus: cphrtxt=85E813540F0AB405.
  - Response: plntxt=0123456789ABCDEF with out_valid exactly 16 cycles after acceptance.
- Backpressure:
  - Stimulus: same vector with out_ready held low for 5 cycles.
  - Response: out_valid and plntxt stay stable at 0123456789ABCDEF, in_ready stays 0, and the transfer completes on the first out_ready cycle.
- Ignored input:
  - Stimulus: pulse in_valid with a different cphrtxt during RUN.
  - Response: no second acceptance, and the output is still the original plaintext.
- Reset mid-op:
  - Stimulus: assert rst at round 8.
  - Response: out_valid=0, busy=0 and in_ready=1 immediately. A new block accepted afterwards decodes correctly.
- Round-trip and throughput:
  - Stimulus: 200 random key/plaintext pairs encrypted by `feistel_network` and streamed back-to-back with out_ready=1.
  - Response: every plntxt matches the original plaintext, with acceptances exactly 18 cycles apart.

Source files
------------

// File: rtl/des_pkg.sv
// des_pkg: widths, FSM state type, subkey array type and DES permutation/S-box tables.
// Revision: 1.0
`default_nettype none

package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [ROUNDS-1:0][SUBKEY_W-1:0] subkey_arr_t;

  // Tables use DES bit numbering: position 1 is the MSB.
  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  localparam int FP_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  // Each box is row-major: index = {row(2), column(4)}.
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
  };

endpackage

`default_nettype wire

// File: rtl/initial_permutation.sv
// initial_permutation: DES IP applied to a 64-bit block.
// Revision: 1.0
`default_nettype none

module initial_permutation
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  output logic [BLOCK_W-1:0] permuted
);

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign permuted[BLOCK_W-1-i] = block[BLOCK_W-IP_TAB[i]];
  end

endmodule

`default_nettype wire

// File: rtl/inv_permutation.sv
// inv_permutation: DES IP^-1 (final permutation) applied to a 64-bit block.
// Revision: 1.0
`default_nettype none

module inv_permutation
  import des_pkg::*;
(
  input  logic [BLOCK_W-1:0] block,
  output logic [BLOCK_W-1:0] permuted
);

  for (genvar i = 0; i < BLOCK_W; i++) begin : g_bit
    assign permuted[BLOCK_W-1-i] = block[BLOCK_W-FP_TAB[i]];
  end

endmodule

`default_nettype wire

// File: rtl/round.sv
// round: one DES Feistel round, next_left = right, next_right = left ^ f(right, key).
// Revision: 1.0
`default_nettype none

module round
  import des_pkg::*;
(
  input  logic [HALF_W-1:0]   left,
  input  logic [HALF_W-1:0]   right,
  input  logic [SUBKEY_W-1:0] key,
  output logic [HALF_W-1:0]   next_left,
  output logic [HALF_W-1:0]   next_right
);

  logic [SUBKEY_W-1:0] expanded;
  logic [SUBKEY_W-1:0] mixed;
  logic [HALF_W-1:0]   sbox_out;
  logic [HALF_W-1:0]   f_out;

  for (genvar i = 0; i < SUBKEY_W; i++) begin : g_expand
    assign expanded[SUBKEY_W-1-i] = right[HALF_W-E_TAB[i]];
  end

  assign mixed = expanded ^ key;

  // Outer bits of each 6-bit group pick the row, inner four the column.
  for (genvar b = 0; b < 8; b++) begin : g_sbox
    logic [5:0] six;
    assign six = mixed[SUBKEY_W-1-6*b -: 6];
    assign sbox_out[HALF_W-1-4*b -: 4] = 4'(SBOX[b][{six[5], six[0], six[4:1]}]);
  end

  for (genvar i = 0; i < HALF_W; i++) begin : g_perm
    assign f_out[HALF_W-1-i] = sbox_out[HALF_W-P_TAB[i]];
  end

  assign next_left  = right;
  assign next_right = left ^ f_out;

endmodule

`default_nettype wire

// File: rtl/subkey_select.sv
// subkey_select: 16:1 mux choosing the round subkey by counter value.
// Revision: 1.0
`default_nettype none

module subkey_select
  import des_pkg::*;
#(
  parameter int SEL_W = 4
) (
  input  subkey_arr_t         subkeys,
  input  logic [SEL_W-1:0]    sel,
  output logic [SUBKEY_W-1:0] key
);

  assign key = subkeys[sel];

endmodule

`default_nettype wire

// File: rtl/feistel_decryptor.sv
// feistel_decryptor: iterative DES decryption, one round per clock, subkeys applied 15 down to 0.
// Revision: 1.0
`default_nettype none

module feistel_decryptor #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cphrtxt,
  input  logic [47:0] subkey_0,
  input  logic [47:0] subkey_1,
  input  logic [47:0] subkey_2,
  input  logic [47:0] subkey_3,
  input  logic [47:0] subkey_4,
  input  logic [47:0] subkey_5,
  input  logic [47:0] subkey_6,
  input  logic [47:0] subkey_7,
  input  logic [47:0] subkey_8,
  input  logic [47:0] subkey_9,
  input  logic [47:0] subkey_10,
  input  logic [47:0] subkey_11,
  input  logic [47:0] subkey_12,
  input  logic [47:0] subkey_13,
  input  logic [47:0] subkey_14,
  input  logic [47:0] subkey_15,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plntxt,
  output logic        busy
);

  import des_pkg::*;

  localparam int CNT_BITS = $clog2(ROUNDS);
  localparam logic [CNT_BITS-1:0] LAST_ROUND = CNT_BITS'(ROUNDS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [HALF_W-1:0]   left_half;
  logic [HALF_W-1:0]   right_half;
  logic [CNT_BITS-1:0] cnt;

  subkey_arr_t         subkeys;
  logic [SUBKEY_W-1:0] round_key;
  logic [BLOCK_W-1:0]  ip_block;
  logic [HALF_W-1:0]   next_left;
  logic [HALF_W-1:0]   next_right;

  assign subkeys = {subkey_15, subkey_14, subkey_13, subkey_12,
                    subkey_11, subkey_10, subkey_9,  subkey_8,
                    subkey_7,  subkey_6,  subkey_5,  subkey_4,
                    subkey_3,  subkey_2,  subkey_1,  subkey_0};

  initial_permutation u_ip (
    .block    (cphrtxt),
    .permuted (ip_block)
  );

  subkey_select #(.SEL_W(CNT_BITS)) u_sel (
    .subkeys (subkeys),
    .sel     (cnt),
    .key     (round_key)
  );

  round u_round (
    .left       (left_half),
    .right      (right_half),
    .key        (round_key),
    .next_left  (next_left),
    .next_right (next_right)
  );

  // The final swap is folded into the {R, L} ordering at the output.
  inv_permutation u_fp (
    .block    ({right_half, left_half}),
    .permuted (plntxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = RUN;
      RUN:     if (cnt == '0)     state_nxt = DONE;
      DONE:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_half  <= '0;
      right_half <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            left_half  <= ip_block[BLOCK_W-1:HALF_W];
            right_half <= ip_block[HALF_W-1:0];
            cnt        <= LAST_ROUND;
          end
        end
        RUN: begin
          left_half  <= next_left;
          right_half <= next_right;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_feistel_decryptor.sv
// tb_feistel_decryptor: scoreboarded random round-trip bench against a behavioural DES model.
// Revision: 1.0
`default_nettype none

module tb_feistel_decryptor;

  typedef logic [15:0][47:0] ks_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] cphrtxt = '0;
  ks_t         sk = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [63:0] plntxt;

  always #5 clk = ~clk;

  feistel_decryptor #(.ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .cphrtxt(cphrtxt),
    .subkey_0(sk[0]),   .subkey_1(sk[1]),   .subkey_2(sk[2]),   .subkey_3(sk[3]),
    .subkey_4(sk[4]),   .subkey_5(sk[5]),   .subkey_6(sk[6]),   .subkey_7(sk[7]),
    .subkey_8(sk[8]),   .subkey_9(sk[9]),   .subkey_10(sk[10]), .subkey_11(sk[11]),
    .subkey_12(sk[12]), .subkey_13(sk[13]), .subkey_14(sk[14]), .subkey_15(sk[15]),
    .out_valid(out_valid), .out_ready(out_ready), .plntxt(plntxt), .busy(busy)
  );

  // ---------------- reference model (standard DES, bit 1 = MSB) ----------------
  int IP_T[$] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                  62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                  57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                  61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  int FP_T[$];
  int E_T[$]  = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                  16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  int P_T[$]  = '{16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
                  2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
  int PC1_T[$] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T[$] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH[16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  int S[8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

  // Output bit i (1-based from MSB of an n-bit result) takes input bit tab[i] of a win-bit word.
  function automatic logic [63:0] perm(input logic [63:0] d, input int win, input int tab[$]);
    logic [63:0] o = '0;
    int n = tab.size();
    for (int i = 0; i < n; i++) o[n-1-i] = d[win-tab[i]];
    return o;
  endfunction

  function automatic ks_t key_sched(input logic [63:0] key);
    ks_t ks;
    logic [55:0] cd;
    logic [27:0] c, d;
    cd = 56'(perm(key, 64, PC1_T));
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[r] = 48'(perm({8'h00, c, d}, 56, PC2_T));
    end
    return ks;
  endfunction

  function automatic logic [31:0] f_model(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [31:0] s;
    logic [5:0]  six;
    e = 48'(perm({32'h0, r}, 32, E_T)) ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = e[47-6*b -: 6];
      s[31-4*b -: 4] = 4'(S[b][({six[5], six[0]} * 16) + six[4:1]]);
    end
    return 32'(perm({32'h0, s}, 32, P_T));
  endfunction

  function automatic logic [63:0] encrypt(input logic [63:0] pt, input ks_t ks);
    logic [63:0] ip;
    logic [31:0] l, r, t;
    ip = perm(pt, 64, IP_T);
    l = ip[63:32];
    r = ip[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_model(r, ks[i]);
      l = t;
    end
    return perm({r, l}, 64, FP_T);
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic [63:0] exp_q[$];
  int cyc = 0;
  int acc_edge = 0;
  int last_acc = -1;
  int n_acc = 0;
  bit stream = 1'b0;
  bit prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        n_acc++;
        acc_edge = cyc + 1;
        if (stream && last_acc >= 0) check("accept_interval", 64'(acc_edge - last_acc), 64'd18);
        last_acc = acc_edge;
      end
      if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_edge), 64'd16);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
        else check("plaintext", plntxt, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus (called at posedge + #1) ----------------
  task automatic send(input logic [63:0] ct, input ks_t ks, input logic [63:0] exp);
    int budget = 0;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    sk = ks;
    cphrtxt = ct;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int budget = 0;
    while (!out_valid && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!out_valid) check("out_valid_timeout", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] FIPS_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] FIPS_PT  = 64'h0123456789ABCDEF;

  initial begin
    ks_t fks, rks;
    logic [63:0] key, pt, ct;
    int exp_acc = 0;

    for (int i = 0; i < 64; i++) FP_T.push_back(0);
    for (int i = 0; i < 64; i++) FP_T[IP_T[i]-1] = i + 1;
    fks = key_sched(FIPS_KEY);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_plntxt",    plntxt, perm(64'h0, 64, FP_T));
    rst = 1'b0;
    @(posedge clk); #1;

    // FIPS vector
    send(FIPS_CT, fks, FIPS_PT);
    exp_acc++;
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    wait_drain();

    // Backpressure
    out_ready = 1'b0;
    send(FIPS_CT, fks, FIPS_PT);
    exp_acc++;
    wait_out_valid();
    repeat (5) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_plntxt",    plntxt, FIPS_PT);
      check("bp_in_ready",  {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_done_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_done_in_ready",  {63'd0, in_ready},  64'd1);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Ignored input during RUN
    send(FIPS_CT, fks, FIPS_PT);
    exp_acc++;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    cphrtxt = {$urandom, $urandom};
    repeat (3) begin
      check("run_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("ignored_accept_count", 64'(n_acc), 64'(exp_acc));

    // Reset mid-operation at round 8
    send(FIPS_CT, fks, FIPS_PT);
    exp_acc++;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy",      {63'd0, busy},      64'd0);
    check("midrst_in_ready",  {63'd0, in_ready},  64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    key = {$urandom, $urandom};
    pt  = {$urandom, $urandom};
    rks = key_sched(key);
    send(encrypt(pt, rks), rks, pt);
    exp_acc++;
    wait_drain();

    // Random round-trip, back-to-back
    stream = 1'b1;
    last_acc = -1;
    for (int n = 0; n < 200; n++) begin
      key = {$urandom, $urandom};
      pt  = {$urandom, $urandom};
      rks = key_sched(key);
      ct  = encrypt(pt, rks);
      send(ct, rks, pt);
      exp_acc++;
    end
    wait_drain();
    stream = 1'b0;
    check("total_accept_count", 64'(n_acc), 64'(exp_acc));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
